// File: rtl/n64_cmd_tx_if.sv
// rtl/n64_cmd_tx_if.sv - command/line bundle between console logic and the N64 transmitter
interface n64_cmd_tx_if #(
  parameter int M = 8
);
  logic         start;
  logic [M-1:0] data;
  logic         line_low;
  logic         busy;
  logic         done;

  modport master (
    output start, data,
    input  line_low, busy, done
  );

  modport slave (
    input  start, data,
    output line_low, busy, done
  );
endinterface

// File: rtl/n64_cmd_tx.sv
// rtl/n64_cmd_tx.sv - N64 single-wire command serialiser, MSB first; N64_TX_STOP_EN adds the stop bit
module n64_cmd_tx #(
  parameter int M         = 8,
  parameter int US_CYCLES = 12
) (
  input  logic           clk,
  input  logic           rstn,
  n64_cmd_tx_if.slave    bus
);
  localparam int UW = $clog2(US_CYCLES);
  localparam int BW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP, DONE} state_t;

  state_t         state, state_n;
  logic [UW-1:0]  us_cnt, us_n;
  logic [1:0]     q_cnt, q_n;
  logic [BW-1:0]  bit_cnt, bit_n;
  logic [M-1:0]   sh, sh_n;
  logic           line_low_r, busy_r, done_r;
  logic           line_low_n, busy_n, done_n;
  logic           us_last, last_bit;

  assign us_last  = (us_cnt == UW'(US_CYCLES - 1));
  assign last_bit = (bit_cnt == BW'(M - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      us_cnt     <= '0;
      q_cnt      <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      line_low_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_n;
      us_cnt     <= us_n;
      q_cnt      <= q_n;
      bit_cnt    <= bit_n;
      sh         <= sh_n;
      line_low_r <= line_low_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    us_n    = us_cnt;
    q_n     = q_cnt;
    bit_n   = bit_cnt;
    sh_n    = sh;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = DATA;
          us_n    = '0;
          q_n     = '0;
          bit_n   = '0;
          sh_n    = bus.data;
        end
      end
      DATA: begin
        if (us_last) begin
          us_n = '0;
          q_n  = q_cnt + 2'd1;
          if (q_cnt == 2'd3) begin
            if (last_bit) begin
`ifdef N64_TX_STOP_EN
              state_n = STOP;
`else
              state_n = DONE;
`endif
            end else begin
              bit_n = bit_cnt + BW'(1);
              sh_n  = sh << 1;
            end
          end
        end else begin
          us_n = us_cnt + UW'(1);
        end
      end
`ifdef N64_TX_STOP_EN
      STOP: begin
        if (us_last) begin
          us_n    = '0;
          state_n = DONE;
        end else begin
          us_n = us_cnt + UW'(1);
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state the next edge will enter.
  always_comb begin
    line_low_n = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    case (state_n)
      DATA: begin
        busy_n     = 1'b1;
        line_low_n = (q_n < (sh_n[M-1] ? 2'd1 : 2'd3));
      end
      STOP: begin
        busy_n     = 1'b1;
        line_low_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  assign bus.line_low = line_low_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_n64_cmd_tx.sv
// tb/tb_n64_cmd_tx.sv - scoreboard bench for n64_cmd_tx (M=8/US=4 and M=1/US=2 instances)
module tb_n64_cmd_tx;
  localparam int US0 = 4;
  localparam int M0  = 8;
  localparam int US1 = 2;
  localparam int M1  = 1;

  logic clk = 1'b0;
  logic rstn0, rstn1;
  always #5 clk = ~clk;

  n64_cmd_tx_if #(.M(M0)) bus0 ();
  n64_cmd_tx_if #(.M(M1)) bus1 ();

  n64_cmd_tx #(.M(M0), .US_CYCLES(US0)) dut0 (.clk(clk), .rstn(rstn0), .bus(bus0.slave));
  n64_cmd_tx #(.M(M1), .US_CYCLES(US1)) dut1 (.clk(clk), .rstn(rstn1), .bus(bus1.slave));

  // Each entry is the expected {line_low, busy, done} for one cycle; empty means idle.
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  bit inst1_finished = 1'b0;

  task automatic push(input int which, input logic [2:0] v);
    if (which == 0) exp_q0.push_back(v);
    else            exp_q1.push_back(v);
  endtask

  task automatic push_frame(input int which, input int m, input int us, input logic [7:0] d);
    for (int i = m - 1; i >= 0; i--) begin
      int low_len;
      low_len = d[i] ? us : 3 * us;
      for (int c = 0; c < 4 * us; c++)
        push(which, (c < low_len) ? 3'b110 : 3'b010);
    end
`ifdef N64_TX_STOP_EN
    for (int c = 0; c < us; c++) push(which, 3'b110);
`endif
    push(which, 3'b001);
  endtask

  always @(negedge clk) begin
    logic [2:0] got, exp;
    got = {bus0.line_low, bus0.busy, bus0.done};
    exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 3'b000;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wave_m8 t=%0t got=%b expected=%b", $time, got, exp);
    end
    got = {bus1.line_low, bus1.busy, bus1.done};
    exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 3'b000;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wave_m1 t=%0t got=%b expected=%b", $time, got, exp);
    end
  end

  task automatic wait_idle0();
    int n = 0;
    while (exp_q0.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        $display("FAIL timeout_m8 remaining=%0d expected=0", exp_q0.size());
        $fatal(1, "timeout");
      end
    end
  endtask

  // hold keeps start high through the end of the frame; poke re-pulses start with new data mid-frame.
  task automatic send0(input logic [7:0] d, input bit hold, input int poke);
    wait_idle0();
    bus0.data  = d;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    push_frame(0, M0, US0, d);
    bus0.start = hold;
    if (poke > 0) begin
      repeat (poke - 1) @(posedge clk);
      #1;
      bus0.start = 1'b1;
      bus0.data  = ~d;
      @(posedge clk); #1;
      bus0.data  = 8'h00;
      bus0.start = hold;
    end
  endtask

  initial begin
    rstn1      = 1'b0;
    bus1.start = 1'b1;
    bus1.data  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn1 = 1'b1;
    bus1.start = 1'b0;
    for (int f = 0; f < 4; f++) begin
      logic [7:0] d;
      int n;
      d = 8'(f == 0 ? 1 : $urandom_range(0, 1));
      bus1.data  = d[0];
      bus1.start = 1'b1;
      @(posedge clk); #1;
      push_frame(1, M1, US1, d);
      bus1.start = (f == 1);
      n = 0;
      while (exp_q1.size() != 0) begin
        @(posedge clk); #1;
        n++;
        if (n > 500) begin
          $display("FAIL timeout_m1 remaining=%0d expected=0", exp_q1.size());
          $fatal(1, "timeout");
        end
      end
    end
    bus1.start = 1'b0;
    inst1_finished = 1'b1;
  end

  initial begin
    rstn0      = 1'b0;
    bus0.start = 1'b1;
    bus0.data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rstn0      = 1'b1;
    bus0.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send0(8'h01, 1'b0, 0);
    send0(8'hA5, 1'b0, 40);
    send0(8'h80, 1'b1, 0);
    send0(8'h7F, 1'b1, 25);
    for (int f = 0; f < 6; f++)
      send0(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 120)) : 0);
    wait_idle0();
    bus0.start = 1'b0;

    send0(8'h3C, 1'b0, 0);
    repeat (49) @(posedge clk);
    #1;
    rstn0 = 1'b0;
    @(posedge clk); #1;
    exp_q0.delete();
    rstn0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send0(8'hC3, 1'b0, 0);
    send0(8'h00, 1'b0, 0);
    send0(8'hFF, 1'b0, 0);
    wait_idle0();
    repeat (3) @(posedge clk);

    for (int n = 0; n < 2000 && !inst1_finished; n++) @(posedge clk);
    if (!inst1_finished) begin
      $display("FAIL inst1_finish got=0 expected=1");
      $fatal(1, "timeout");
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/n64_cmd_tx.md
# n64_cmd_tx

Console-side transmitter for the N64 controller single-wire bus. It loads an M-bit command word and serialises it MSB first using N64 pulse-width bit encoding, with an optional stop bit. The line is driven by an external open-drain pad. It is the transmit counterpart of the `shiftM` serial-in capture path: the command it sends (e.g. 0x01 poll) triggers the controller reply that `shiftM` collects.

## Interface
Parameters:
- `M`, default 8: command length in bits.
- `US_CYCLES`, default 12: clock cycles per microsecond (12 MHz board clock). Legal minimum is 2.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rstn`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: request a frame. Sampled only in IDLE.
- `data`, input, M: command word. Captured on the cycle `start` is accepted.
- `line_low`, output, 1: 1 = pad drives the line low; 0 = line released (pulled high).
- `busy`, output, 1: a frame is in progress.
- `done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- Time base:
  - A microsecond counter counts 0..US_CYCLES-1.
  - A quarter counter counts 0..3 and advances when the microsecond counter wraps.
  - One bit cell is 4 µs = 4·US_CYCLES cycles.
- Bit encoding:
  - Bit 0: low 3 µs, then high 1 µs.
  - Bit 1: low 1 µs, then high 3 µs.
  - Stop bit: low 1 µs, then release.
- Bit order is MSB first. A shift register loaded from `data` shifts left once per completed bit cell.
- States:
  - IDLE:
    - `line_low`=0, `busy`=0.
    - `start`=1 captures `data`, clears both counters and the bit counter, and goes to DATA.
  - DATA:
    - `line_low`=1 while quarter < (bit ? 1 : 3), otherwise 0.
    - At the end of a cell, if the bit counter is M-1, go to STOP (or DONE if the stop bit is compiled out). Otherwise increment the bit counter and shift.
  - STOP:
    - `line_low`=1 for exactly US_CYCLES cycles, then go to DONE.
  - DONE:
    - `done`=1 and `busy`=0 for one cycle, `line_low`=0, then go to IDLE.
- `start` outside IDLE is ignored; `data` changes during a frame have no effect.
- `rstn`=0 in any state, on the next edge:
  - state returns to IDLE and all counters clear;
  - `line_low`=0, `busy`=0, `done`=0;
  - any frame in progress is abandoned with no `done` pulse.
- Reset values: `line_low`=0, `busy`=0, `done`=0, shift register 0.

## Timing
- All outputs are registered.
- Start latency: if `start` is accepted at edge k, `busy` and the first low pulse begin at cycle k+1.
- Frame length, counted from cycle k+1:
  - 4·US_CYCLES·M cycles of data;
  - plus US_CYCLES cycles of stop (if compiled in);
  - `done` follows in the next cycle.
- Back-to-back frames: `start` held high during DONE is not accepted. The earliest next accept is the IDLE cycle after DONE, so there is at least 1 cycle of release between frames.
- M=1 is legal and produces a single cell.

## Configuration
- `N64_TX_STOP_EN`:
  - Defined: the STOP state is present and every frame ends with a 1 µs low stop bit.
  - Undefined: STOP is removed, DATA goes directly to DONE after the last cell, and the frame is US_CYCLES cycles shorter.

## Test plan
Unless stated otherwise, parameters are US_CYCLES=4, M=8, and `start` is accepted at edge 0.

- Reset: `rstn`=0 for 3 cycles with `start`=1 → `line_low`, `busy` and `done` stay 0; no frame starts.
- `data`=8'h01, `N64_TX_STOP_EN` defined:
  - seven cells of 12 low / 4 high, then one cell of 4 low / 12 high;
  - stop low during cycles 129..132;
  - `done`=1 at cycle 133 only; `busy` high during cycles 1..132.
- `data`=8'h01, macro undefined → same data cells, no stop low, `done`=1 at cycle 129.
- `data`=8'hA5, `start` re-pulsed at cycle 40 and `data` changed to 8'h00 → waveform still encodes 1010_0101 and there is exactly one `done` pulse.
- `rstn`=0 at cycle 50 mid-frame → `line_low`=0 and `busy`=0 at cycle 51; no `done`; a new `start` at cycle 53 produces a full frame.
- M=1, `data`=1'b1, US_CYCLES=2 → low 2, high 6, stop low 2, `done` at cycle 11.
